// File: rtl/sdram_arb_pkg.sv
// sdram_arb_pkg: shared configuration, FSM state, port ID and command types for sdram_arb
package sdram_arb_pkg;
  localparam int NUM_PORTS  = 4;
  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
  localparam int MAX_RD     = 4;
  localparam int ID_W       = $clog2(NUM_PORTS);
  typedef enum logic {ARB, ISSUE} arb_state_e;
  typedef logic [ID_W-1:0] port_id_t;
  typedef struct packed {
    logic                    we;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
  } sdram_cmd_t;
  function automatic port_id_t next_port(input port_id_t p);
    return (p == port_id_t'(NUM_PORTS - 1)) ? '0 : port_id_t'(p + 1'b1);
  endfunction
endpackage

// File: rtl/sdram_arb_if.sv
// sdram_arb_if: requester-side and controller-side buses of sdram_arb
//   sdram_req_if : req_valid/ready/we/addr/wdata/wstrb per port, rsp_valid per port, rsp_rdata broadcast
//                  master = requesters, slave = arbiter
//   sdram_ctrl_if: ctrl_valid/ready/we/addr/wdata/wstrb command, ctrl_rvalid/rdata in-order read data
//                  master = arbiter, slave = SDRAM controller
interface sdram_req_if;
  import sdram_arb_pkg::*;
  logic [NUM_PORTS-1:0]                   req_valid;
  logic [NUM_PORTS-1:0]                   req_ready;
  logic [NUM_PORTS-1:0]                   req_we;
  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0]   req_addr;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]   req_wdata;
  logic [NUM_PORTS-1:0][DATA_WIDTH/8-1:0] req_wstrb;
  logic [NUM_PORTS-1:0]                   rsp_valid;
  logic [DATA_WIDTH-1:0]                  rsp_rdata;
  modport master (output req_valid, req_we, req_addr, req_wdata, req_wstrb,
                  input  req_ready, rsp_valid, rsp_rdata);
  modport slave  (input  req_valid, req_we, req_addr, req_wdata, req_wstrb,
                  output req_ready, rsp_valid, rsp_rdata);
endinterface

interface sdram_ctrl_if;
  import sdram_arb_pkg::*;
  logic                    ctrl_valid;
  logic                    ctrl_ready;
  logic                    ctrl_we;
  logic [ADDR_WIDTH-1:0]   ctrl_addr;
  logic [DATA_WIDTH-1:0]   ctrl_wdata;
  logic [DATA_WIDTH/8-1:0] ctrl_wstrb;
  logic                    ctrl_rvalid;
  logic [DATA_WIDTH-1:0]   ctrl_rdata;
  modport master (output ctrl_valid, ctrl_we, ctrl_addr, ctrl_wdata, ctrl_wstrb,
                  input  ctrl_ready, ctrl_rvalid, ctrl_rdata);
  modport slave  (input  ctrl_valid, ctrl_we, ctrl_addr, ctrl_wdata, ctrl_wstrb,
                  output ctrl_ready, ctrl_rvalid, ctrl_rdata);
endinterface

// File: rtl/sdram_arb_idfifo.sv
// sdram_arb_idfifo: sync FIFO of port IDs for outstanding reads, head read combinationally
//   clk, rst_n (async active-low), push/din, pop/dout, full, empty; push+pop while full is legal
module sdram_arb_idfifo
  import sdram_arb_pkg::*;
#(
  parameter int DEPTH = MAX_RD
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     push,
  input  port_id_t din,
  input  logic     pop,
  output port_id_t dout,
  output logic     full,
  output logic     empty
);
  localparam int PW = $clog2(DEPTH);
  port_id_t      mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  logic          wr_en, rd_en;
  assign full  = count == (PW+1)'(DEPTH);
  assign empty = count == '0;
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);
  assign dout  = mem[rd_ptr];
  always_ff @(posedge clk)
    if (wr_en) mem[wr_ptr] <= din;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (PW+1)'(wr_en) - (PW+1)'(rd_en);
    end
endmodule

// File: rtl/sdram_arb.sv
// sdram_arb: round-robin N-port arbiter onto one SDRAM controller channel with in-order read routing
//   clk, rst_n (async active-low), req (sdram_req_if.slave), ctrl (sdram_ctrl_if.master),
//   rsp_orphan (sticky: read data arrived with no outstanding read)
//   SDRAM_ARB_PRIO0_EN: port 0 always wins when valid; RR among the rest
module sdram_arb
  import sdram_arb_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  sdram_req_if.slave   req,
  sdram_ctrl_if.master ctrl,
  output logic         rsp_orphan
);
`ifdef SDRAM_ARB_PRIO0_EN
  localparam bit PRIO0 = 1'b1;
`else
  localparam bit PRIO0 = 1'b0;
`endif
  arb_state_e           state;
  port_id_t             rr_ptr, winner, pick, k, head;
  sdram_cmd_t           cmd;
  logic [NUM_PORTS-1:0] cand;
  logic                 grant, push, pop, full, empty;
  // Descending scan so the candidate closest after rr_ptr is written last and wins.
  always_comb begin
    cand = req.req_valid & ~NUM_PORTS'(PRIO0);
    pick = '0;
    k    = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      k = port_id_t'((int'(rr_ptr) + i) % NUM_PORTS);
      if (cand[k]) pick = k;
    end
    if (PRIO0 && req.req_valid[0]) pick = '0;
  end
  // A full ID FIFO blocks every grant, writes included, so ordering stays trivial.
  assign grant            = rst_n && state == ARB && |req.req_valid && !full;
  assign req.req_ready    = grant ? NUM_PORTS'(1) << pick : '0;
  assign push             = state == ISSUE && ctrl.ctrl_ready && !cmd.we;
  assign pop              = ctrl.ctrl_rvalid && !empty;
  assign req.rsp_valid    = pop ? NUM_PORTS'(1) << head : '0;
  assign req.rsp_rdata    = ctrl.ctrl_rdata;
  assign ctrl.ctrl_valid  = state == ISSUE;
  assign ctrl.ctrl_we     = cmd.we;
  assign ctrl.ctrl_addr   = cmd.addr;
  assign ctrl.ctrl_wdata  = cmd.wdata;
  assign ctrl.ctrl_wstrb  = cmd.wstrb;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state  <= ARB;
      rr_ptr <= '0;
      winner <= '0;
      cmd    <= '0;
    end else if (state == ARB) begin
      if (grant) begin
        state  <= ISSUE;
        winner <= pick;
        cmd    <= '{we: req.req_we[pick], addr: req.req_addr[pick],
                    wdata: req.req_wdata[pick], wstrb: req.req_wstrb[pick]};
      end
    end else if (ctrl.ctrl_ready) begin
      state  <= ARB;
      rr_ptr <= (PRIO0 && winner == '0) ? rr_ptr : next_port(winner);
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rsp_orphan <= 1'b0;
    else if (ctrl.ctrl_rvalid && empty) rsp_orphan <= 1'b1;
  sdram_arb_idfifo #(.DEPTH(MAX_RD)) u_idfifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (winner),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );
endmodule

// File: tb/tb_sdram_arb.sv
// tb_sdram_arb: randomized self-checking bench for sdram_arb against a grant/response reference model
module tb_sdram_arb;
  import sdram_arb_pkg::*;
  localparam int N = NUM_PORTS;
`ifdef SDRAM_ARB_PRIO0_EN
  localparam bit PRIO0 = 1'b1;
`else
  localparam bit PRIO0 = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rsp_orphan;
  int tests = 0;
  int fails = 0;
  int rr = 0;
  int idq[$];
  logic [DATA_WIDTH-1:0] dq[$];
  logic [N-1:0] pats[$];

  sdram_req_if  req ();
  sdram_ctrl_if ctrl ();

  sdram_arb dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .ctrl       (ctrl),
    .rsp_orphan (rsp_orphan)
  );

  always #5 clk = ~clk;

  function automatic int model_pick(input logic [N-1:0] v, input int p);
    int j;
    if (PRIO0 && v[0]) return 0;
    for (int i = 0; i < N; i++) begin
      j = (p + i) % N;
      if (((int'(v) >> j) & 1) == 1 && !(PRIO0 && j == 0)) return j;
    end
    return -1;
  endfunction

  function automatic int next_rr(input int w, input int cur);
    return (PRIO0 && w == 0) ? cur : (w + 1) % N;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_reads;
    logic [N-1:0] exp_rsp;
    logic [ADDR_WIDTH-1:0] a;
    int w;
    ctrl.ctrl_ready = 1'b1;
    req.req_we = '0;
    for (int n = 0; n < pats.size(); n++) begin
      req.req_valid = pats[n];
      ctrl.ctrl_rvalid = idq.size() > 0;
      ctrl.ctrl_rdata = idq.size() > 0 ? dq[0] : '0;
      #1;
      w = model_pick(pats[n], rr);
      exp_rsp = idq.size() > 0 ? N'(1) << idq[0] : '0;
      tests++;
      if (req.req_ready !== N'(1) << w) begin
        fails++;
        $display("FAIL grant[%0d]: req_ready=%b expected %b", n, req.req_ready, N'(1) << w);
      end
      tests++;
      if (req.rsp_valid !== exp_rsp || (idq.size() > 0 && req.rsp_rdata !== dq[0])) begin
        fails++;
        $display("FAIL rsp[%0d]: rsp_valid=%b rdata=%h expected %b %h", n, req.rsp_valid, req.rsp_rdata, exp_rsp, idq.size() > 0 ? dq[0] : '0);
      end
      if (idq.size() > 0) begin
        void'(idq.pop_front());
        void'(dq.pop_front());
      end
      a = req.req_addr[port_id_t'(w)];
      tick;
      ctrl.ctrl_rvalid = 1'b0;
      req.req_addr[port_id_t'(w)] = $urandom;
      #1;
      tests++;
      if ({ctrl.ctrl_valid, ctrl.ctrl_we, ctrl.ctrl_addr, req.req_ready} !== {1'b1, 1'b0, a, N'(0)}) begin
        fails++;
        $display("FAIL issue[%0d]: valid=%b we=%b addr=%h ready=%b expected 1 0 %h 0", n, ctrl.ctrl_valid, ctrl.ctrl_we, ctrl.ctrl_addr, req.req_ready, a);
      end
      tick;
      idq.push_back(w);
      dq.push_back(DATA_WIDTH'(a ^ 32'h5a5a_5a5a));
      rr = next_rr(w, rr);
    end
    req.req_valid = '0;
    while (idq.size() > 0) begin
      ctrl.ctrl_rvalid = 1'b1;
      ctrl.ctrl_rdata = dq[0];
      #1;
      tests++;
      if (req.rsp_valid !== N'(1) << idq[0] || req.rsp_rdata !== dq[0]) begin
        fails++;
        $display("FAIL drain: rsp_valid=%b rdata=%h expected %b %h", req.rsp_valid, req.rsp_rdata, N'(1) << idq[0], dq[0]);
      end
      void'(idq.pop_front());
      void'(dq.pop_front());
      tick;
    end
    ctrl.ctrl_rvalid = 1'b0;
  endtask

  task automatic test_reset;
    req.req_valid = '1;
    ctrl.ctrl_rvalid = 1'b1;
    tick;
    tick;
    tests++;
    if ({req.req_ready, ctrl.ctrl_valid, req.rsp_valid, rsp_orphan} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: ready=%b ctrl_valid=%b rsp_valid=%b orphan=%b expected all 0", req.req_ready, ctrl.ctrl_valid, req.rsp_valid, rsp_orphan);
    end
    tests++;
    if ({ctrl.ctrl_we, ctrl.ctrl_addr, ctrl.ctrl_wdata, ctrl.ctrl_wstrb} !== '0) begin
      fails++;
      $display("FAIL reset_fields: we=%b addr=%h wdata=%h wstrb=%h expected 0", ctrl.ctrl_we, ctrl.ctrl_addr, ctrl.ctrl_wdata, ctrl.ctrl_wstrb);
    end
    req.req_valid = '0;
    ctrl.ctrl_rvalid = 1'b0;
    tick;
    rst_n = 1'b1;
    rr = 0;
    idq.delete();
    dq.delete();
  endtask

  task automatic test_rr_reads;
    for (int p = 0; p < N; p++) req.req_addr[port_id_t'(p)] = $urandom;
    pats.delete();
    for (int i = 0; i < 8; i++) pats.push_back('1);
    for (int i = 0; i < 10; i++) pats.push_back(N'($urandom_range(1, (1 << N) - 1)));
    run_reads;
  endtask

  task automatic test_fifo_full;
    logic [N-1:0] v;
    logic [ADDR_WIDTH-1:0] a;
    int w;
    ctrl.ctrl_ready = 1'b1;
    req.req_we = '0;
    for (int p = 0; p < N; p++) req.req_addr[port_id_t'(p)] = $urandom;
    for (int n = 0; n <= MAX_RD; n++) begin
      v = N'($urandom_range(1, (1 << N) - 1));
      req.req_valid = v;
      if (n == MAX_RD) begin
        for (int c = 0; c < 4; c++) begin
          #1;
          tests++;
          if ({req.req_ready, ctrl.ctrl_valid} !== '0) begin
            fails++;
            $display("FAIL full_block[%0d]: ready=%b ctrl_valid=%b expected 0 0", c, req.req_ready, ctrl.ctrl_valid);
          end
          tick;
        end
        ctrl.ctrl_rvalid = 1'b1;
        ctrl.ctrl_rdata = dq[0];
        #1;
        tests++;
        if (req.rsp_valid !== N'(1) << idq[0] || req.rsp_rdata !== dq[0]) begin
          fails++;
          $display("FAIL full_pop: rsp_valid=%b rdata=%h expected %b %h", req.rsp_valid, req.rsp_rdata, N'(1) << idq[0], dq[0]);
        end
        void'(idq.pop_front());
        void'(dq.pop_front());
        tick;
        ctrl.ctrl_rvalid = 1'b0;
      end
      #1;
      w = model_pick(v, rr);
      tests++;
      if (req.req_ready !== N'(1) << w) begin
        fails++;
        $display("FAIL full_grant[%0d]: req_ready=%b expected %b", n, req.req_ready, N'(1) << w);
      end
      a = req.req_addr[port_id_t'(w)];
      tick;
      req.req_valid = '0;
      req.req_addr[port_id_t'(w)] = $urandom;
      #1;
      tests++;
      if ({ctrl.ctrl_valid, ctrl.ctrl_addr} !== {1'b1, a}) begin
        fails++;
        $display("FAIL full_issue[%0d]: valid=%b addr=%h expected 1 %h", n, ctrl.ctrl_valid, ctrl.ctrl_addr, a);
      end
      tick;
      idq.push_back(w);
      dq.push_back(DATA_WIDTH'($urandom));
      rr = next_rr(w, rr);
    end
    while (idq.size() > 0) begin
      ctrl.ctrl_rvalid = 1'b1;
      ctrl.ctrl_rdata = dq[0];
      #1;
      tests++;
      if (req.rsp_valid !== N'(1) << idq[0] || req.rsp_rdata !== dq[0]) begin
        fails++;
        $display("FAIL full_drain: rsp_valid=%b rdata=%h expected %b %h", req.rsp_valid, req.rsp_rdata, N'(1) << idq[0], dq[0]);
      end
      void'(idq.pop_front());
      void'(dq.pop_front());
      tick;
    end
    ctrl.ctrl_rvalid = 1'b0;
  endtask

  task automatic test_stall;
    logic [N-1:0] v;
    logic [ADDR_WIDTH+DATA_WIDTH+DATA_WIDTH/8:0] exp_cmd;
    int w;
    ctrl.ctrl_ready = 1'b0;
    req.req_we = '1;
    for (int p = 0; p < N; p++) begin
      req.req_addr[port_id_t'(p)] = $urandom;
      req.req_wdata[port_id_t'(p)] = $urandom;
      req.req_wstrb[port_id_t'(p)] = (DATA_WIDTH/8)'($urandom);
    end
    v = N'($urandom_range(1, (1 << N) - 1));
    req.req_valid = v;
    #1;
    w = model_pick(v, rr);
    tests++;
    if (req.req_ready !== N'(1) << w) begin
      fails++;
      $display("FAIL stall_grant: req_ready=%b expected %b", req.req_ready, N'(1) << w);
    end
    exp_cmd = {1'b1, req.req_addr[port_id_t'(w)], req.req_wdata[port_id_t'(w)], req.req_wstrb[port_id_t'(w)]};
    tick;
    for (int c = 0; c < 10; c++) begin
      req.req_addr[port_id_t'(w)] = $urandom;
      req.req_wdata[port_id_t'(w)] = $urandom;
      req.req_wstrb[port_id_t'(w)] = (DATA_WIDTH/8)'($urandom);
      #1;
      tests++;
      if ({ctrl.ctrl_valid, req.req_ready, ctrl.ctrl_we, ctrl.ctrl_addr, ctrl.ctrl_wdata, ctrl.ctrl_wstrb} !== {1'b1, N'(0), exp_cmd}) begin
        fails++;
        $display("FAIL stall_hold[%0d]: valid=%b ready=%b cmd=%h expected 1 0 %h", c, ctrl.ctrl_valid, req.req_ready, {ctrl.ctrl_we, ctrl.ctrl_addr, ctrl.ctrl_wdata, ctrl.ctrl_wstrb}, exp_cmd);
      end
      tick;
    end
    ctrl.ctrl_ready = 1'b1;
    req.req_valid = '0;
    tick;
    rr = next_rr(w, rr);
    ctrl.ctrl_ready = 1'b0;
    #1;
    tests++;
    if (ctrl.ctrl_valid !== 1'b0) begin
      fails++;
      $display("FAIL stall_accept: ctrl_valid=%b expected 0", ctrl.ctrl_valid);
    end
    req.req_we = '0;
  endtask

  task automatic test_write;
    logic [DATA_WIDTH-1:0] d;
    d = $urandom;
    ctrl.ctrl_ready = 1'b1;
    req.req_we = N'(1) << 2;
    req.req_addr[2] = ADDR_WIDTH'(32'h100);
    req.req_wdata[2] = d;
    req.req_wstrb[2] = (DATA_WIDTH/8)'(4'b0011);
    req.req_valid = N'(1) << 2;
    #1;
    tests++;
    if (req.req_ready !== N'(1) << model_pick(N'(1) << 2, rr)) begin
      fails++;
      $display("FAIL wr_grant: req_ready=%b expected %b", req.req_ready, N'(1) << 2);
    end
    tick;
    req.req_valid = '0;
    #1;
    tests++;
    if ({ctrl.ctrl_valid, ctrl.ctrl_we} !== 2'b11) begin
      fails++;
      $display("FAIL wr_valid_we: valid=%b we=%b expected 1 1", ctrl.ctrl_valid, ctrl.ctrl_we);
    end
    tests++;
    if (ctrl.ctrl_addr !== ADDR_WIDTH'(32'h100)) begin
      fails++;
      $display("FAIL wr_addr: got %h expected 00000100", ctrl.ctrl_addr);
    end
    tests++;
    if (ctrl.ctrl_wdata !== d || ctrl.ctrl_wstrb !== (DATA_WIDTH/8)'(4'b0011)) begin
      fails++;
      $display("FAIL wr_data: wdata=%h wstrb=%b expected %h 0011", ctrl.ctrl_wdata, ctrl.ctrl_wstrb, d);
    end
    tick;
    rr = next_rr(2, rr);
    ctrl.ctrl_ready = 1'b0;
    req.req_we = '0;
  endtask

  task automatic test_orphan;
    #1;
    tests++;
    if (rsp_orphan !== 1'b0) begin
      fails++;
      $display("FAIL orphan_pre: got %b expected 0", rsp_orphan);
    end
    ctrl.ctrl_rvalid = 1'b1;
    ctrl.ctrl_rdata = $urandom;
    #1;
    tests++;
    if (req.rsp_valid !== '0) begin
      fails++;
      $display("FAIL orphan_rsp: rsp_valid=%b expected 0", req.rsp_valid);
    end
    tick;
    ctrl.ctrl_rvalid = 1'b0;
    tick;
    tick;
    tests++;
    if (rsp_orphan !== 1'b1) begin
      fails++;
      $display("FAIL orphan_sticky: got %b expected 1", rsp_orphan);
    end
  endtask

  task automatic test_prio0;
    for (int p = 0; p < N; p++) req.req_addr[port_id_t'(p)] = $urandom;
    pats.delete();
    for (int i = 0; i < 6; i++) pats.push_back(N'(1) | (N'(1) << 3));
    for (int i = 0; i < 2; i++) pats.push_back(N'(1) << 3);
    run_reads;
  endtask

  task automatic test_reset_issue;
    int w;
    ctrl.ctrl_ready = 1'b1;
    req.req_we = '0;
    req.req_valid = N'(1) << $urandom_range(0, N - 1);
    #1;
    w = model_pick(req.req_valid, rr);
    tests++;
    if (req.req_ready !== N'(1) << w) begin
      fails++;
      $display("FAIL rst_first_grant: req_ready=%b expected %b", req.req_ready, N'(1) << w);
    end
    tick;
    req.req_valid = '0;
    tick;
    rr = next_rr(w, rr);
    ctrl.ctrl_ready = 1'b0;
    req.req_valid = N'(1) << $urandom_range(0, N - 1);
    #1;
    w = model_pick(req.req_valid, rr);
    tests++;
    if (req.req_ready !== N'(1) << w) begin
      fails++;
      $display("FAIL rst_second_grant: req_ready=%b expected %b", req.req_ready, N'(1) << w);
    end
    tick;
    #1;
    tests++;
    if ({ctrl.ctrl_valid, rsp_orphan} !== 2'b11) begin
      fails++;
      $display("FAIL rst_pre: ctrl_valid=%b orphan=%b expected 1 1", ctrl.ctrl_valid, rsp_orphan);
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if ({ctrl.ctrl_valid, rsp_orphan, req.req_ready} !== '0) begin
      fails++;
      $display("FAIL rst_async: ctrl_valid=%b orphan=%b ready=%b expected 0 0 0", ctrl.ctrl_valid, rsp_orphan, req.req_ready);
    end
    tick;
    rst_n = 1'b1;
    rr = 0;
    idq.delete();
    dq.delete();
    req.req_valid = '1;
    #1;
    tests++;
    if (req.req_ready !== N'(1) << model_pick('1, rr)) begin
      fails++;
      $display("FAIL rst_rr_ptr: req_ready=%b expected %b", req.req_ready, N'(1) << model_pick('1, rr));
    end
    req.req_valid = '0;
    ctrl.ctrl_rvalid = 1'b1;
    #1;
    tests++;
    if (req.rsp_valid !== '0) begin
      fails++;
      $display("FAIL rst_fifo_empty: rsp_valid=%b expected 0", req.rsp_valid);
    end
    tick;
    ctrl.ctrl_rvalid = 1'b0;
    #1;
    tests++;
    if (rsp_orphan !== 1'b1) begin
      fails++;
      $display("FAIL rst_orphan_again: got %b expected 1", rsp_orphan);
    end
  endtask

  initial begin
    req.req_valid = '0;
    req.req_we = '0;
    req.req_addr = '0;
    req.req_wdata = '0;
    req.req_wstrb = '0;
    ctrl.ctrl_ready = 1'b0;
    ctrl.ctrl_rvalid = 1'b0;
    ctrl.ctrl_rdata = '0;
    test_reset;
    test_rr_reads;
    test_fifo_full;
    test_stall;
    test_write;
    test_orphan;
    test_prio0;
    test_reset_issue;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end
endmodule
